uart_baud_gen: RTL

Parametrised successor to the single-rate UART bit-clock divider. Generates bit strobes for two independent channels: RX samples at mid-bit, TX shifts at the bit boundary. Baud rate is runtime-selectable from five standard rates. Each channel frames itself: it counts bits and reports frame completion. Sits between the 50 MHz system clock domain and the uart_rx / uart_tx shifters.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_chan.sv | 103 ++++++++++
 rtl/uart_baud_gen.sv | 80 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud generator: rate select codes, channel
// states and the divisor helper used to build the rate lookup.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_sel_e;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

    localparam int FRAME_BITS_DEF = 10;

    // Unlisted select codes fall back to the slowest rate.
    function automatic int baud_of(input logic [2:0] sel);
        case (sel)
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            BAUD_115200: return 115200;
            default:     return 9600;
        endcase
    endfunction

    // Terminal count of the divider: one bit period is div_of()+1 clocks.
    function automatic int div_of(input int clk_hz, input logic [2:0] sel);
        return clk_hz / baud_of(sel) - 1;
    endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// One strobe channel: IDLE/RUN framing FSM, divider and bit counters.
// PHASE_MID=1 strobes at mid-bit (RX), PHASE_MID=0 at the bit boundary (TX).
module uart_baud_chan
    import uart_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter bit PHASE_MID  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] half,
    output logic             strobe,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit;
    logic             finish;

    assign hit = (state_q == CH_RUN) && (cnt_q == phase_q) && (bitcnt_q != LAST_BIT);

    // RX ends on the stop-bit centre strobe; TX runs the last bit out to its end.
    assign finish = (state_q == CH_RUN) && (bitcnt_q == LAST_BIT) &&
                    (PHASE_MID ? strobe_q : (cnt_q == div_q));

    always_comb begin
        // NOTE: every _d is defaulted before the branches so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        if (state_q == CH_RUN) begin
            cnt_d = (cnt_q == div_q) ? '0 : cnt_q + CNT_ONE;
            if (hit) begin
                strobe_d = 1'b1;
                bitcnt_d = bitcnt_q + BIT_ONE;
            end
            if (finish) begin
                done_d  = 1'b1;
                state_d = CH_IDLE;
            end
        end

        // Start is honoured from IDLE or on the finishing cycle, never mid-frame.
        if (start && (state_q == CH_IDLE || finish)) begin
            state_d  = CH_RUN;
            cnt_d    = '0;
            bitcnt_d = '0;
            div_d    = div;
            phase_d  = PHASE_MID ? half : '0;
        end

        busy_d = (state_d == CH_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            phase_q  <= '0;
            bitcnt_q <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign strobe = strobe_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Two-channel UART bit-strobe generator: selects the divisor for the current
// rate and feeds independent RX (mid-bit) and TX (bit-boundary) channels.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_sel,
    input  logic       rx_start,
    output logic       rx_clk_bps,
    output logic       rx_busy,
    output logic       rx_done,
    input  logic       tx_start,
    output logic       tx_clk_bps,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV_9600   = div_of(CLK_HZ, BAUD_9600);
    localparam int DIV_19200  = div_of(CLK_HZ, BAUD_19200);
    localparam int DIV_38400  = div_of(CLK_HZ, BAUD_38400);
    localparam int DIV_57600  = div_of(CLK_HZ, BAUD_57600);
    localparam int DIV_115200 = div_of(CLK_HZ, BAUD_115200);

    // The slowest rate has the largest divisor, so it bounds the counter width.
    if (longint'(DIV_9600) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
        $error("uart_baud_gen: CNT_W=%0d cannot hold divisor %0d", CNT_W, DIV_9600);
    end

    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] half_sel;

    always_comb begin
        div_sel = CNT_W'(DIV_9600);
        case (baud_sel)
            BAUD_19200:  div_sel = CNT_W'(DIV_19200);
            BAUD_38400:  div_sel = CNT_W'(DIV_38400);
            BAUD_57600:  div_sel = CNT_W'(DIV_57600);
            BAUD_115200: div_sel = CNT_W'(DIV_115200);
            default:     div_sel = CNT_W'(DIV_9600);
        endcase
    end

    assign half_sel = div_sel >> 1;

    uart_baud_chan #(
        .CNT_W      (CNT_W),
        .FRAME_BITS (FRAME_BITS),
        .PHASE_MID  (1'b1)
    ) u_rx_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (rx_start),
        .div    (div_sel),
        .half   (half_sel),
        .strobe (rx_clk_bps),
        .busy   (rx_busy),
        .done   (rx_done)
    );

    uart_baud_chan #(
        .CNT_W      (CNT_W),
        .FRAME_BITS (FRAME_BITS),
        .PHASE_MID  (1'b0)
    ) u_tx_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tx_start),
        .div    (div_sel),
        .half   (half_sel),
        .strobe (tx_clk_bps),
        .busy   (tx_busy),
        .done   (tx_done)
    );

endmodule
